// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Framing and overrun errors are reported as sticky flags cleared by err_clr.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               uart_s_in,
  input  logic                               rd_en,
  output logic [7:0]                         rd_data,
  output logic                               rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
  output logic                               frame_err,
  output logic                               overrun,
  input  logic                               err_clr
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  logic [1:0] sync_q, sync_d;
  logic       rxs_prev_q, rxs_prev_d;
  logic       rxs;

  always_comb begin
    sync_d     = {sync_q[0], uart_s_in};
    rxs_prev_d = sync_q[1];
  end
  assign rxs = sync_q[1];

  // Synchronizer resets to the idle-line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
    end
  end

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          ferr_set_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_q   <= S_START;
            timer_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        S_START: begin
          if (timer_q == HALF_M1) begin
            timer_q <= '0;
            state_q <= rxs ? S_IDLE : S_DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DATA: begin
          if (timer_q == BIT_M1) begin
            timer_q   <= '0;
            shift_q   <= {rxs, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_STOP: begin
          if (timer_q == BIT_M1) begin
            timer_q <= '0;
            if (rxs) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_set_q <= 1'b1;
              state_q    <= S_WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        // A held-low line (break) must not be re-deframed as a stream of 0x00.
        S_WAIT_HIGH: if (rxs) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          full, empty, pop, do_push;

  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    pop      = rd_en && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    do_push  = push_q && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    overrun_d   = (push_q && full && !pop) || (overrun_q && !err_clr);
    frame_err_d = ferr_set_q || (frame_err_q && !err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign rx_valid  = !empty;
  assign rx_count  = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, uart_s_in, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       rx_valid, frame_err, overrun;
  logic [2:0] rx_count;

  int n_chk = 0;
  int n_err = 0;
  int n;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .uart_s_in(uart_s_in), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val);
    tick(1);
    uart_s_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_s_in = b[i];
      tick(CPB);
    end
    uart_s_in = stop_val;
    tick(stop_len);
    uart_s_in = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; uart_s_in = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    tick(5);

    // Single byte with latency measured from the start edge.
    fork
      send_frame(8'hA5, CPB, 1'b1);
      begin
        tick(1);
        n = 0;
        while (!rx_valid && n < 400) begin
          @(posedge clk); #2;
          n++;
        end
      end
    join
    chk("a5_latency", n, 3 + 8 + 144 + 1);
    chk("a5_count", rx_count, 1);
    pop_chk("a5_data", 8'hA5);
    chk("a5_empty", rx_valid, 0);
    chk("a5_count0", rx_count, 0);

    // Back-to-back frames, no reads.
    send_frame(8'h01, CPB, 1'b1);
    send_frame(8'h80, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    send_frame(8'h00, CPB, 1'b1);
    tick(2);
    chk("b2b_count", rx_count, 4);
    chk("b2b_ferr", frame_err, 0);
    chk("b2b_ovr", overrun, 0);
    pop_chk("b2b_0", 8'h01);
    pop_chk("b2b_1", 8'h80);
    pop_chk("b2b_2", 8'hFF);
    pop_chk("b2b_3", 8'h00);
    chk("b2b_empty", rx_valid, 0);

    // Overrun on a full FIFO.
    send_frame(8'h11, CPB, 1'b1);
    send_frame(8'h22, CPB, 1'b1);
    send_frame(8'h33, CPB, 1'b1);
    send_frame(8'h44, CPB, 1'b1);
    send_frame(8'h3C, CPB, 1'b1);
    tick(2);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", rx_count, 4);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    pop_chk("ovr_0", 8'h11);
    pop_chk("ovr_1", 8'h22);
    pop_chk("ovr_2", 8'h33);
    pop_chk("ovr_3", 8'h44);
    chk("ovr_empty", rx_count, 0);

    // Full FIFO with a pop on the exact push cycle.
    send_frame(8'hA1, CPB, 1'b1);
    send_frame(8'hB2, CPB, 1'b1);
    send_frame(8'hC3, CPB, 1'b1);
    send_frame(8'hD4, CPB, 1'b1);
    fork
      send_frame(8'h3C, CPB, 1'b1);
      begin
        tick(1);
        tick(155);
        chk("pp_head", rd_data, 8'hA1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("pp_count_now", rx_count, 4);
      end
    join
    tick(2);
    chk("pp_ovr", overrun, 0);
    chk("pp_count", rx_count, 4);
    pop_chk("pp_0", 8'hB2);
    pop_chk("pp_1", 8'hC3);
    pop_chk("pp_2", 8'hD4);
    pop_chk("pp_last", 8'h3C);
    chk("pp_empty", rx_valid, 0);

    // Stop bit held low for three bit times.
    send_frame(8'h55, 3 * CPB, 1'b0);
    tick(5);
    chk("fe_set", frame_err, 1);
    chk("fe_nopush", rx_valid, 0);
    send_frame(8'h12, CPB, 1'b1);
    tick(2);
    chk("fe_next_cnt", rx_count, 1);
    pop_chk("fe_next", 8'h12);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("fe_clr", frame_err, 0);

    // Short low glitch on an idle line.
    tick(1);
    uart_s_in = 1'b0;
    tick(4);
    uart_s_in = 1'b1;
    tick(200);
    chk("gl_valid", rx_valid, 0);
    chk("gl_ferr", frame_err, 0);
    chk("gl_ovr", overrun, 0);

    // Asynchronous reset in the middle of a data bit, with a byte held.
    send_frame(8'h77, CPB, 1'b1);
    tick(2);
    chk("pre_rst_data", rd_data, 8'h77);
    fork
      send_frame(8'h5A, CPB, 1'b1);
      begin
        tick(1);
        tick(60);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", rx_valid, 0);
        chk("ar_count", rx_count, 0);
        chk("ar_data", rd_data, 8'h00);
        chk("ar_ferr", frame_err, 0);
        chk("ar_ovr", overrun, 0);
      end
    join
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("post_rst_idle", rx_valid, 0);
    send_frame(8'hC3, CPB, 1'b1);
    tick(2);
    chk("post_rst_cnt", rx_count, 1);
    pop_chk("post_rst_data", 8'hC3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a receive FIFO for the 3-stage pipelined RISC-V processor. It consumes the processor's serial input line, deframes 8N1 characters, and buffers the bytes. The memory/writeback stage pops the bytes through a memory-mapped read path. It replaces raw sampling of the serial pin with a clean, flow-controlled byte source and sticky error flags.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200). Must be ≥ 4.
- FIFO_DEPTH, 8, receive FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- uart_s_in  in  1  serial receive line. Asynchronous to clk. Idle high.
- rd_en  in  1  pop request from the MW stage. Pops the head entry when rx_valid=1.
- rd_data  out  8  FIFO head byte (first-word-fall-through). Valid only when rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  $clog2(FIFO_DEPTH+1)  number of bytes held.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte arrived while the FIFO was full.
- err_clr  in  1  clears frame_err and overrun.

## Operation
- Input conditioning: two-flop synchronizer on uart_s_in, then a registered copy for edge detect. All FSM decisions use the synchronized value `rxs`.
- FSM states and transitions:
  - IDLE: a falling edge on rxs goes to START with bit counter = 0 and timer = 0.
  - START: wait CLKS_PER_BIT/2 cycles (integer division) to reach mid-bit. If rxs=1 there, treat it as a glitch and return to IDLE with no flags set. Otherwise go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register. Bits arrive LSB first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs at mid-stop.
    - If the sample is 1: push the byte and return to IDLE.
    - If the sample is 0: set frame_err, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from producing repeated 0x00 characters.
- FIFO: circular buffer with pointers of width $clog2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, plus a separate count register.
  - Push when full and no pop in the same cycle: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both are performed, no overrun, and the count is unchanged.
  - Push and pop in the same cycle when empty: only the push occurs. There is no bypass; the new byte appears the next cycle.
  - rd_en while empty is ignored. It has no effect on pointers or flags.
- Sticky flags: a set event takes priority over err_clr in the same cycle.
- Reset mid-frame: the FSM aborts to IDLE and the partial byte is lost. The FIFO is emptied.

## Timing
- Reset values:
  - FSM = IDLE; pointers, count and timer = 0.
  - rx_valid=0, rx_count=0, rd_data=8'h00, frame_err=0, overrun=0.
  - Synchronizer flops reset to 1 (idle line).
- Detection latency: a falling edge on uart_s_in is seen in IDLE 3 cycles later (2 synchronizer flops + edge register).
- Sampling points relative to the detected edge:
  - Start bit: cycle CLKS_PER_BIT/2.
  - Data bit k (k = 0..7): cycle CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit: cycle CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Push: occurs on the stop-sample cycle. rx_valid, rx_count and rd_data update on the next clock edge.
- Pop: rd_en=1 with rx_valid=1 advances the head on that edge. The next byte (or rx_valid=0) is visible in the following cycle.
- Back-to-back frames: a falling edge arriving any time after the stop sample is accepted. There is no dead time beyond returning to IDLE.
- Tolerance: reception is correct with up to ±4% baud mismatch.

## Test plan
Benches use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Reset, then send 0xA5 (8N1 at 16 clk/bit): rx_valid rises 3+8+144+1 cycles after the start edge, rd_data=0xA5, rx_count=1. After one rd_en pulse: rx_valid=0, rx_count=0.
- Send 0x01, 0x80, 0xFF, 0x00 back-to-back without reads: rx_count=4. Popping returns them in order with no flags set.
- With the FIFO full, send 0x3C: overrun=1 and the contents are still the original 4 bytes. Pulse err_clr: overrun=0.
- With the FIFO full, assert rd_en on the exact push cycle of 0x3C: overrun stays 0, rx_count stays 4, and the last byte popped is 0x3C.
- Send 0x55 with the stop bit held low for 3 bit times, then idle: frame_err=1, nothing is pushed, and the next valid frame 0x12 is received correctly.
- Inject a 4-cycle low glitch on an idle line: no push and no flags. Assert rst in the middle of a DATA bit: all outputs return to their reset values immediately (asynchronous reset).
